// File: rtl/mem_bus_if.sv
// Data-memory bus between the MEM-stage access unit (master) and memory (slave).
interface mem_bus_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, wstrb, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wstrb, wdata, output rdata, ack);
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: turns EX/MEM ops into req/ack bus transfers and stalls until done.
// Optional bus timeout enabled by defining MEM_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  mem_bus_if.master   dbus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t      state;
  logic        is_load, is_store, is_signed;
  size_t       size;
  logic        op_valid, misaligned, start;
  logic [3:0]  wstrb_next;
  logic [31:0] wdata_next;
  logic [31:0] load_data_q, ext_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Op fields latched at IDLE->REQ; only these are used once the transfer is under way.
  logic        lat_load, lat_signed;
  size_t       lat_size;
  logic [1:0]  lat_lane;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    size      = SZ_W;
    case (mem_op_i)
      4'd1:    begin is_load  = 1'b1; is_signed = 1'b1; size = SZ_B; end
      4'd2:    begin is_load  = 1'b1; is_signed = 1'b1; size = SZ_H; end
      4'd3:    begin is_load  = 1'b1; size = SZ_W; end
      4'd4:    begin is_load  = 1'b1; size = SZ_B; end
      4'd5:    begin is_load  = 1'b1; size = SZ_H; end
      4'd9:    begin is_store = 1'b1; size = SZ_B; end
      4'd10:   begin is_store = 1'b1; size = SZ_H; end
      4'd11:   begin is_store = 1'b1; size = SZ_W; end
      default: ;
    endcase
  end

  assign op_valid   = is_load | is_store;
  assign misaligned = ((size == SZ_H) && mem_addr_i[0]) ||
                      ((size == SZ_W) && (mem_addr_i[1:0] != 2'b00));
  assign start      = op_valid && !misaligned;

  // Combinational flags are forced low while reset is held, matching the registered outputs.
  assign misalign_o  = rst_n && op_valid && misaligned;
  assign stall_o     = rst_n && (((state == IDLE) && start) || (state == REQ));
  assign load_data_o = (is_load && misaligned) ? 32'd0 : load_data_q;

  always_comb begin
    wstrb_next = 4'b0000;
    wdata_next = mem_wdata_i;
    case (size)
      SZ_B: begin
        wstrb_next = 4'b0001 << mem_addr_i[1:0];
        wdata_next = {4{mem_wdata_i[7:0]}};
      end
      SZ_H: begin
        wstrb_next = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{mem_wdata_i[15:0]}};
      end
      default: wstrb_next = 4'b1111;
    endcase
    if (is_load) wstrb_next = 4'b0000;
  end

  always_comb begin
    case (lat_lane)
      2'd0:    byte_sel = dbus.rdata[7:0];
      2'd1:    byte_sel = dbus.rdata[15:8];
      2'd2:    byte_sel = dbus.rdata[23:16];
      default: byte_sel = dbus.rdata[31:24];
    endcase
    half_sel = lat_lane[1] ? dbus.rdata[31:16] : dbus.rdata[15:0];
    case (lat_size)
      SZ_B:    ext_data = {{24{lat_signed & byte_sel[7]}}, byte_sel};
      SZ_H:    ext_data = {{16{lat_signed & half_sel[15]}}, half_sel};
      default: ext_data = dbus.rdata;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
`else
  assign bus_err_o = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dbus.req    <= 1'b0;
      dbus.we     <= 1'b0;
      dbus.addr   <= 32'd0;
      dbus.wstrb  <= 4'd0;
      dbus.wdata  <= 32'd0;
      load_data_q <= 32'd0;
      lat_load    <= 1'b0;
      lat_signed  <= 1'b0;
      lat_size    <= SZ_W;
      lat_lane    <= 2'd0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt    <= '0;
      bus_err_o   <= 1'b0;
`endif
    end else begin
`ifdef MEM_TIMEOUT_EN
      bus_err_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            state      <= REQ;
            dbus.req   <= 1'b1;
            dbus.we    <= is_store;
            dbus.addr  <= {mem_addr_i[31:2], 2'b00};
            dbus.wstrb <= wstrb_next;
            dbus.wdata <= wdata_next;
            lat_load   <= is_load;
            lat_signed <= is_signed;
            lat_size   <= size;
            lat_lane   <= mem_addr_i[1:0];
`ifdef MEM_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
          end else if (is_load && misaligned) begin
            load_data_q <= 32'd0;
          end
        end
        REQ: begin
          if (dbus.ack) begin
            dbus.req <= 1'b0;
            if (lat_load) load_data_q <= ext_data;
            state    <= DONE;
`ifdef MEM_TIMEOUT_EN
          end else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            dbus.req    <= 1'b0;
            bus_err_o   <= 1'b1;
            load_data_q <= 32'd0;
            state       <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus random ops against a behavioural model.
module tb_mem_access_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr, mem_wdata;
  logic        stall, misalign, bus_err;
  logic [31:0] load_data;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] ld_model = 32'd0;

  mem_bus_if dbus ();

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_op_i    (mem_op),
    .mem_addr_i  (mem_addr),
    .mem_wdata_i (mem_wdata),
    .stall_o     (stall),
    .load_data_o (load_data),
    .misalign_o  (misalign),
    .bus_err_o   (bus_err),
    .dbus        (dbus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit op_is_load(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd5);
  endfunction

  function automatic bit op_is_store(input logic [3:0] op);
    return (op >= 4'd9) && (op <= 4'd11);
  endfunction

  // Access size in bytes, 0 for no-op codes.
  function automatic int op_bytes(input logic [3:0] op);
    case (op)
      4'd1, 4'd4, 4'd9:  return 1;
      4'd2, 4'd5, 4'd10: return 2;
      4'd3, 4'd11:       return 4;
      default:           return 0;
    endcase
  endfunction

  function automatic logic [31:0] load_model(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> ((a % 4) * 8)) & 32'hFF;
    h = (rd >> (((a / 2) % 2) * 16)) & 32'hFFFF;
    case (op)
      4'd1:    return (b >= 128) ? b - 32'd256 : b;
      4'd2:    return (h >= 32768) ? h - 32'd65536 : h;
      4'd3:    return rd;
      4'd4:    return b;
      default: return h;
    endcase
  endfunction

  function automatic logic [3:0] strb_model(input logic [3:0] op, input logic [31:0] a);
    case (op_bytes(op))
      1:       return 4'(1 << (a % 4));
      2:       return 4'(3 << (a % 4));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] wdata_model(input logic [3:0] op, input logic [31:0] w);
    case (op_bytes(op))
      1:       return (w & 32'hFF) * 32'h01010101;
      2:       return (w & 32'hFFFF) * 32'h00010001;
      default: return w;
    endcase
  endfunction

  // Presents one op and runs it to completion, acking in REQ cycle number dly.
  task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input int dly);
    bit ld, st, mis;
    ld  = op_is_load(op);
    st  = op_is_store(op);
    mis = (op_bytes(op) != 0) && ((addr % op_bytes(op)) != 0);
    @(posedge clk); #1;
    mem_op = op; mem_addr = addr; mem_wdata = wd; dbus.ack = 1'b0;
    @(negedge clk);
    if (!(ld || st)) begin
      check("none_stall", stall, 0);
      check("none_misalign", misalign, 0);
      check("none_req", dbus.req, 0);
      check("none_ldata", load_data, ld_model);
      return;
    end
    if (mis) begin
      if (ld) ld_model = 32'd0;
      check("mis_flag", misalign, 1);
      check("mis_stall", stall, 0);
      check("mis_ldata", load_data, ld_model);
      @(negedge clk);
      check("mis_req", dbus.req, 0);
      check("mis_stall2", stall, 0);
      return;
    end
    check("idle_stall", stall, 1);
    check("idle_misalign", misalign, 0);
    check("idle_req", dbus.req, 0);
    for (int k = 1; k <= dly; k++) begin
      @(posedge clk); #1;
      dbus.ack   = (k == dly);
      dbus.rdata = (k == dly) ? rd : $urandom;
      @(negedge clk);
      check("req_req", dbus.req, 1);
      check("req_stall", stall, 1);
      check("req_we", dbus.we, st);
      check("req_addr", dbus.addr, addr & 32'hFFFF_FFFC);
      check("req_wstrb", dbus.wstrb, ld ? 4'h0 : strb_model(op, addr));
      if (st) check("req_wdata", dbus.wdata, wdata_model(op, wd));
    end
    @(posedge clk); #1;
    dbus.ack = 1'b0;
    if (ld) ld_model = load_model(op, addr, rd);
    @(negedge clk);
    check("done_stall", stall, 0);
    check("done_req", dbus.req, 0);
    check("done_ldata", load_data, ld_model);
    check("done_buserr", bus_err, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_misalign"}, misalign, 0);
    check({tag, "_ldata"}, load_data, 0);
    check({tag, "_buserr"}, bus_err, 0);
    check({tag, "_req"}, dbus.req, 0);
    check({tag, "_we"}, dbus.we, 0);
    check({tag, "_addr"}, dbus.addr, 0);
    check({tag, "_wstrb"}, dbus.wstrb, 0);
    check({tag, "_wdata"}, dbus.wdata, 0);
  endtask

  initial begin
    logic [3:0] ops [10];
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd11, 4'd7};
    rst_n = 1'b0; mem_op = 4'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
    dbus.ack = 1'b0; dbus.rdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;

    // Directed cases
    do_op(4'd3,  32'h100, 32'd0, 32'hDEADBEEF, 1);
    check("lw_value", load_data, 32'hDEADBEEF);
    do_op(4'd9,  32'h103, 32'h000000A5, 32'h0, 3);
    do_op(4'd1,  32'h102, 32'd0, 32'h12F05678, 1);
    check("lb_value", load_data, 32'hFFFFFFF0);
    do_op(4'd4,  32'h102, 32'd0, 32'h12F05678, 2);
    check("lbu_value", load_data, 32'h000000F0);
    do_op(4'd2,  32'h102, 32'd0, 32'h12F05678, 1);
    check("lh_value", load_data, 32'h000012F0);
    do_op(4'd10, 32'h206, 32'h0000BEEF, 32'h0, 1);
    do_op(4'd3,  32'h101, 32'd0, 32'h0, 1);
    check("lw_mis_value", load_data, 32'h0);
    do_op(4'd11, 32'h20C, 32'hCAFEF00D, 32'h0, TO);
    do_op(4'd5,  32'h300, 32'd0, 32'h0000_8001, 1);
    check("lhu_value", load_data, 32'h00008001);

    // Reset in the third REQ cycle of a slow load; the late ack must be ignored.
    @(posedge clk); #1;
    mem_op = 4'd3; mem_addr = 32'h400; dbus.ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_req", dbus.req, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    ld_model = 32'd0;
    mem_op = 4'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dbus.ack = 1'b1; dbus.rdata = 32'h55AA55AA;
    repeat (2) begin
      @(negedge clk);
      check("late_ack_req", dbus.req, 0);
      check("late_ack_stall", stall, 0);
      check("late_ack_ldata", load_data, 0);
    end
    dbus.ack = 1'b0;
    do_op(4'd3, 32'h404, 32'd0, 32'h01234567, 2);

`ifdef MEM_TIMEOUT_EN
    // No ack: the wait limit ends the transfer with an error pulse.
    @(posedge clk); #1;
    mem_op = 4'd3; mem_addr = 32'h500; dbus.ack = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("to_req", dbus.req, 1);
      check("to_buserr_wait", bus_err, 0);
    end
    @(negedge clk);
    ld_model = 32'd0;
    check("to_buserr", bus_err, 1);
    check("to_req_drop", dbus.req, 0);
    check("to_stall", stall, 0);
    check("to_ldata", load_data, 0);
    @(posedge clk); #1;
    mem_op = 4'd0;
    @(negedge clk);
    check("to_buserr_pulse", bus_err, 0);
`endif

    // Random ops against the model
    for (int i = 0; i < 60; i++) begin
      do_op(ops[$urandom_range(0, 9)], $urandom, $urandom, $urandom, $urandom_range(1, TO));
    end

    @(posedge clk); #1;
    mem_op = 4'd0;
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store engine. Sits between the EX/MEM pipeline register outputs and the data-memory bus.
- Converts the registered memory op, address and store data into a req/ack bus transaction, and stalls the pipeline until the transaction completes.
- Returns sign- or zero-extended load data, aligned for the MEM/WB register.
- Detects misaligned accesses; these never reach the bus.

Parameters:
- TIMEOUT_CYCLES, 255: bus wait limit in cycles. Used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_op_i  in  4  op from EX/MEM: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 9 SB, 10 SH, 11 SW. Other codes are treated as none.
- mem_addr_i  in  32  byte address (ALU result)
- mem_wdata_i  in  32  store source (rD2)
- stall_o  out  1  hold IF/ID/EX and EX/MEM registers
- load_data_o  out  32  extended load result for MEM/WB
- misalign_o  out  1  misaligned access flag
- bus_err_o  out  1  one-cycle timeout pulse
- dbus_req_o  out  1  bus request
- dbus_we_o  out  1  1 = write
- dbus_addr_o  out  32  word address, bits [1:0] = 0
- dbus_wstrb_o  out  4  byte enables
- dbus_wdata_o  out  32  lane-replicated store data
- dbus_rdata_i  in  32  read data, valid with ack
- dbus_ack_i  in  1  transfer complete

Behaviour:
- Reset is asynchronous and active-low, on rst_n; clock is clk.
- Reset values: state IDLE, stall_o 0, load_data_o 0, misalign_o 0, bus_err_o 0, and all dbus_* outputs 0. Any outstanding transaction is abandoned; a late ack after reset is ignored.
- Alignment check (combinational):
  - Halfword ops are misaligned if addr[0] = 1.
  - Word ops are misaligned if addr[1:0] != 0.
  - misalign_o = valid op AND misaligned, in the same cycle.
  - A misaligned op issues no bus request and never raises stall_o. load_data_o is 0 for a misaligned load.
- FSM states: IDLE, REQ, DONE.
  - IDLE:
    - Valid, aligned op → REQ next edge.
    - At that edge, register dbus_req_o = 1, dbus_we_o, addr {a[31:2], 2'b00}, wstrb and wdata.
    - stall_o = 1 combinationally while in IDLE with a valid, aligned op.
  - REQ:
    - dbus_req_o and all dbus_* outputs are held stable until dbus_ack_i is sampled high.
    - stall_o = 1.
    - On ack: capture the extended load data (loads only), drop dbus_req_o at the next edge, → DONE.
    - An ack in IDLE or DONE is ignored.
  - DONE:
    - stall_o = 0 for exactly one cycle, so the pipeline advances.
    - load_data_o is valid this cycle.
    - → IDLE unconditionally.
    - The next op is evaluated in IDLE the following cycle. Back-to-back ops therefore take at least 3 cycles each.
- Minimum latency: 3 cycles from op presentation to stall release (ack in the first REQ cycle).
- Write strobes:
  - SB: 4'b0001 << a[1:0]; data {4{wdata[7:0]}}.
  - SH: a[1] ? 4'b1100 : 4'b0011; data {2{wdata[15:0]}}.
  - SW: 4'b1111.
  - Loads: wstrb 0.
- Load extraction:
  - Select the byte (a[1:0]) or halfword (a[1]) lane from rdata.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes rdata.
- For store ops and op none, load_data_o holds its previous value.
- The op inputs are assumed stable while stall_o = 1, which the pipeline guarantees. The unit latches the op at the IDLE→REQ edge and uses only the latched copy thereafter.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A wait counter clears on REQ entry and increments each REQ cycle without ack.
  - When the count reaches TIMEOUT_CYCLES: drop dbus_req_o, pulse bus_err_o for one cycle, set load_data_o to 0, → DONE.
  - If ack arrives in the same cycle as the limit, the ack wins and no error is flagged.
- Not defined: no counter; REQ waits indefinitely; bus_err_o is tied to 0.

Test Plan:
- LW at 0x100, ack 1 cycle after req, rdata 0xDEADBEEF → dbus_addr 0x100, wstrb 0, stall high 2 cycles, load_data 0xDEADBEEF in DONE.
- SB at 0x103, wdata 0x000000A5 → wstrb 4'b1000, wdata 0xA5A5A5A5, we=1, req held until ack.
- LB at 0x102, rdata 0x12F05678 → load_data 0xFFFFFFF0. LBU at the same address → 0x000000F0. LH at 0x102 → 0x000012F0.
- LW at 0x101 → misalign_o 1, stall_o 0, dbus_req_o never asserted.
- Ack delayed 5 cycles; assert rst_n low in the 3rd REQ cycle → all outputs 0 immediately, state IDLE, late ack ignored.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → bus_err_o pulses once, req drops, load_data 0, stall released.
